// File: rtl/scroll_pkg.sv
// Shared constants for the scroll controller: default geometry, step-counter
// width and FSM state encodings.
// Optional feature macro: SCROLL_LEFT_EN (see scroll_step_calc).
package scroll_pkg;

  localparam int unsigned W_DEF          = 10;
  localparam int unsigned BG_MAX_DEF     = 325;
  localparam int unsigned RIGHT_EDGE_DEF = 270;
  localparam int unsigned LEFT_EDGE_DEF  = 90;
  localparam int unsigned MAX_STEP_DEF   = 4;
  localparam int unsigned STEP_CW_DEF    = $clog2(MAX_STEP_DEF + 1);

  // FSM state encodings
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EVAL = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_SNAP = 3'd4;

endpackage

// File: rtl/scroll_ctrl_if.sv
// Game-logic <-> camera bus.
//   frame_tick, char_X, lock, snap_req, snap_pos : game logic -> camera
//   snap_ack, bg_pos, scroll_valid, scroll_dir   : camera -> game/renderer
// master = game-logic side, slave = scroll_ctrl.
interface scroll_ctrl_if
  import scroll_pkg::*;
#(
  parameter int unsigned W = W_DEF
);
  logic         frame_tick;
  logic [W-1:0] char_X;
  logic         lock;
  logic         snap_req;
  logic [W-1:0] snap_pos;
  logic         snap_ack;
  logic [W-1:0] bg_pos;
  logic         scroll_valid;
  logic         scroll_dir;

  modport master (
    output frame_tick, char_X, lock, snap_req, snap_pos,
    input  snap_ack, bg_pos, scroll_valid, scroll_dir
  );

  modport slave (
    input  frame_tick, char_X, lock, snap_req, snap_pos,
    output snap_ack, bg_pos, scroll_valid, scroll_dir
  );
endinterface

// File: rtl/scroll_step_calc.sv
// Combinational dead-zone evaluation: returns the clamped per-frame scroll
// step and its direction (1 = right, 0 = left).
//   bg_pos, char_X : current background offset and character position
//   step_c, dir_c  : step size (0 = no scroll) and direction
// Left scrolling is only built when SCROLL_LEFT_EN is defined.
module scroll_step_calc
  import scroll_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned BG_MAX     = BG_MAX_DEF,
  parameter int unsigned RIGHT_EDGE = RIGHT_EDGE_DEF,
  parameter int unsigned MAX_STEP   = MAX_STEP_DEF
`ifdef SCROLL_LEFT_EN
  ,
  parameter int unsigned LEFT_EDGE  = LEFT_EDGE_DEF
`endif
) (
  input  logic [W-1:0]                     bg_pos,
  input  logic [W-1:0]                     char_X,
  output logic [$clog2(MAX_STEP + 1)-1:0]  step_c,
  output logic                             dir_c
);

  localparam int unsigned CW = $clog2(MAX_STEP + 1);

  function automatic logic [W:0] min2(input logic [W:0] a, input logic [W:0] b);
    return (a < b) ? a : b;
  endfunction

  // One extra bit so edge sums never wrap
  logic [W:0] bg_x;
  logic [W:0] ch_x;
  logic [W:0] r_lim;
  logic [W:0] step_w;

  assign bg_x  = {1'b0, bg_pos};
  assign ch_x  = {1'b0, char_X};
  assign r_lim = bg_x + (W+1)'(RIGHT_EDGE);

`ifdef SCROLL_LEFT_EN
  logic [W:0] l_lim;
  assign l_lim = bg_x + (W+1)'(LEFT_EDGE);
`endif

  // Right check first: it wins if both edges are crossed
  always_comb begin
    step_w = '0;
    dir_c  = 1'b1;
    if (ch_x > r_lim) begin
      step_w = min2(min2(ch_x - r_lim, (W+1)'(MAX_STEP)),
                    (W+1)'(BG_MAX) - bg_x);
      dir_c  = 1'b1;
    end
`ifdef SCROLL_LEFT_EN
    else if ((bg_x != '0) && (ch_x < l_lim)) begin
      step_w = min2(min2(l_lim - ch_x, (W+1)'(MAX_STEP)), bg_x);
      dir_c  = 1'b0;
    end
`endif
  end

  // step_w never exceeds MAX_STEP, so the narrowing is lossless
  assign step_c = CW'(step_w);

endmodule

// File: rtl/scroll_ctrl.sv
// Frame-synchronous camera controller. Once per frame it evaluates the
// character against the dead-zone edges and walks bg_pos one pixel per
// cycle, or snaps it to a requested position; lock freezes evaluation.
//   sys_clk, rst : clock and synchronous active-high reset
//   bus          : scroll_ctrl_if slave (tick/char/lock/snap in,
//                  bg_pos/snap_ack/scroll_valid/scroll_dir out, all registered)
// Optional feature macro: SCROLL_LEFT_EN enables leftward scrolling.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned BG_MAX     = BG_MAX_DEF,
  parameter int unsigned RIGHT_EDGE = RIGHT_EDGE_DEF,
  parameter int unsigned MAX_STEP   = MAX_STEP_DEF
`ifdef SCROLL_LEFT_EN
  ,
  parameter int unsigned LEFT_EDGE  = LEFT_EDGE_DEF
`endif
) (
  input logic           sys_clk,
  input logic           rst,
  scroll_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_STEP + 1);

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  bg_q, bg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
  logic          sdir_q, sdir_d;

  logic [CW-1:0] calc_step_c;
  logic          calc_dir_c;

  scroll_step_calc #(
    .W          (W),
    .BG_MAX     (BG_MAX),
    .RIGHT_EDGE (RIGHT_EDGE),
    .MAX_STEP   (MAX_STEP)
`ifdef SCROLL_LEFT_EN
    ,
    .LEFT_EDGE  (LEFT_EDGE)
`endif
  ) u_calc (
    .bg_pos (bg_q),
    .char_X (bus.char_X),
    .step_c (calc_step_c),
    .dir_c  (calc_dir_c)
  );

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bg_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      sdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      sdir_q  <= sdir_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    sdir_d  = sdir_q;
    case (state_q)
      S_IDLE: begin
        // Ticks outside IDLE are ignored; snap beats lock beats evaluate
        if (bus.frame_tick) begin
          if (bus.snap_req)  state_d = S_SNAP;
          else if (!bus.lock) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (calc_step_c == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = calc_step_c;
          dir_d   = calc_dir_c;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        bg_d  = dir_q ? (bg_q + W'(1)) : (bg_q - W'(1));
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        valid_d = 1'b1;
        sdir_d  = dir_q;
        state_d = S_IDLE;
      end
      S_SNAP: begin
        bg_d    = (bus.snap_pos > W'(BG_MAX)) ? W'(BG_MAX) : bus.snap_pos;
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.bg_pos       = bg_q;
  assign bus.snap_ack     = ack_q;
  assign bus.scroll_valid = valid_q;
  assign bus.scroll_dir   = sdir_q;

endmodule
